// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder:
// store-size encodings (funct3) and MMIO register offsets.
package data_mem_responder_pkg;

    // Store sizes, funct3 encoding as used by the CPU MEM stage
    localparam logic [2:0] WT_SB = 3'b000;
    localparam logic [2:0] WT_SH = 3'b001;
    localparam logic [2:0] WT_SW = 3'b010;

    // MMIO offsets from the window base
    localparam logic [27:0] MMIO_CYCLE_LO  = 28'h000_0000;
    localparam logic [27:0] MMIO_CYCLE_HI  = 28'h000_0004;
    localparam logic [27:0] MMIO_TOHOST    = 28'h000_0008;
    localparam logic [27:0] MMIO_STORE_CNT = 28'h000_000C;

    // The MMIO window is decoded on the top address nibble only
    function automatic logic is_mmio_addr(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return addr[31:28] == base[31:28];
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the CPU MEM stage (master)
// and the memory responder (slave).
interface data_mem_responder_if;

    logic        ram_write;
    logic [2:0]  write_type;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        output ram_write,
        output write_type,
        output mem_addr,
        output mem_write_data,
        input  mem_read_data
    );

    modport slave (
        input  ram_write,
        input  write_type,
        input  mem_addr,
        input  mem_write_data,
        output mem_read_data
    );

endinterface

// File: rtl/data_mem_responder_store_lane_gen.sv
// Store lane generator: turns size/offset/data into byte
// enables and lane-positioned data, and flags bad stores.
module store_lane_gen
    import data_mem_responder_pkg::*;
(
    input  logic [2:0]  write_type,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] lane_data,
    output logic        illegal
);

    // Decode size into lanes; an illegal store enables no lane
    always_comb begin
        be        = 4'b0000;
        lane_data = 32'h0;
        illegal   = 1'b0;
        case (write_type)
            WT_SB: begin
                be        = 4'b0001 << addr;
                lane_data = {4{wdata[7:0]}};
            end
            WT_SH: begin
                illegal   = addr[0];
                be        = addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata[15:0]}};
            end
            WT_SW: begin
                illegal   = (addr != 2'b00);
                be        = 4'b1111;
                lane_data = wdata;
            end
            default: begin
                illegal   = 1'b1;
            end
        endcase
        if (illegal) begin
            be = 4'b0000;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with byte-lane stores,
// MMIO counters, tohost halt register and sticky store fault.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_responder_if.slave   bus,
    output logic                  halt,
    output logic [31:0]           halt_code,
    output logic                  fault,
    output logic [31:0]           fault_addr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem_q [0:DEPTH-1];

    logic        halt_q, halt_d;
    logic [31:0] halt_code_q, halt_code_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [63:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] store_cnt_q, store_cnt_d;

    logic                  is_mmio;
    logic [27:0]           mmio_off;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [3:0]            lane_be;
    logic [31:0]           lane_data;
    logic                  lane_illegal;
    logic                  store_req;
    logic                  store_bad;
    logic                  ram_we;
    logic                  tohost_we;
    logic [31:0]           mmio_rdata;

    assign is_mmio  = is_mmio_addr(bus.mem_addr, MMIO_BASE);
    assign mmio_off = bus.mem_addr[27:0];
    assign word_idx = bus.mem_addr[ADDR_WIDTH+1:2];

    store_lane_gen u_lane (
        .write_type (bus.write_type),
        .addr       (bus.mem_addr[1:0]),
        .wdata      (bus.mem_write_data),
        .be         (lane_be),
        .lane_data  (lane_data),
        .illegal    (lane_illegal)
    );

    // Classify the store: halted stores are invisible entirely
    always_comb begin
        store_req = bus.ram_write & ~halt_q;
        store_bad = lane_illegal
                  | (is_mmio & (bus.write_type != WT_SW));
        ram_we    = store_req & ~store_bad & ~is_mmio & ~rst;
        tohost_we = store_req & ~store_bad & is_mmio
                  & (mmio_off == MMIO_TOHOST);
    end

    // Next-state for MMIO registers, counters and fault capture
    always_comb begin
        halt_d       = halt_q;
        halt_code_d  = halt_code_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        store_cnt_d  = store_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        if (!halt_q) begin
            cycle_cnt_d = cycle_cnt_q + 64'd1;
        end
        if (tohost_we) begin
            halt_code_d = bus.mem_write_data;
            halt_d      = (bus.mem_write_data != 32'h0);
        end
        if (store_req && store_bad) begin
            fault_d = 1'b1;
            if (!fault_q) begin
                fault_addr_d = bus.mem_addr;
            end
        end
        if (ram_we && (store_cnt_q != 32'hFFFF_FFFF)) begin
            store_cnt_d = store_cnt_q + 32'd1;
        end
    end

    // Register state; reset wins over a same-cycle store
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q       <= 1'b0;
            halt_code_q  <= 32'h0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
            cycle_cnt_q  <= 64'h0;
            store_cnt_q  <= 32'h0;
        end else begin
            halt_q       <= halt_d;
            halt_code_q  <= halt_code_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            cycle_cnt_q  <= cycle_cnt_d;
            store_cnt_q  <= store_cnt_d;
        end
    end

    // RAM byte-lane write; contents are not reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_be[i]) begin
                    mem_q[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    // MMIO read mux; unmapped offsets read as zero
    always_comb begin
        mmio_rdata = 32'h0;
        case (mmio_off)
            MMIO_CYCLE_LO:  mmio_rdata = cycle_cnt_q[31:0];
            MMIO_CYCLE_HI:  mmio_rdata = cycle_cnt_q[63:32];
            MMIO_TOHOST:    mmio_rdata = halt_code_q;
            MMIO_STORE_CNT: mmio_rdata = store_cnt_q;
            default:        mmio_rdata = 32'h0;
        endcase
    end

    assign bus.mem_read_data = is_mmio ? mmio_rdata : mem_q[word_idx];

    assign halt       = halt_q;
    assign halt_code  = halt_code_q;
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        halt;
    logic [31:0] halt_code;
    logic        fault;
    logic [31:0] fault_addr;

    int errors = 0;
    int checks = 0;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .ADDR_WIDTH (12),
        .MMIO_BASE  (32'h1000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .halt       (halt),
        .halt_code  (halt_code),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at a negedge with rst low
    task automatic do_reset();
        rst = 1'b1;
        bus.ram_write = 1'b0;
        bus.write_type = 3'b010;
        bus.mem_addr = 32'h0;
        bus.mem_write_data = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; one posedge commits the store
    task automatic do_store(input logic [2:0] wt,
                            input logic [31:0] a,
                            input logic [31:0] d);
        bus.ram_write = 1'b1;
        bus.write_type = wt;
        bus.mem_addr = a;
        bus.mem_write_data = d;
        @(negedge clk);
        bus.ram_write = 1'b0;
    endtask

    // Combinational read inside the current cycle
    task automatic do_read(input logic [31:0] a,
                           output logic [31:0] v);
        bus.ram_write = 1'b0;
        bus.mem_addr = a;
        #1;
        v = bus.mem_read_data;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        @(negedge clk);
        do_reset();
        do_read(32'h1000_0000, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL rst_cycle_lo got %h want %h", v, 32'h0);
        end
        do_read(32'h1000_000C, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL rst_store_cnt got %h want %h", v, 32'h0);
        end
        checks++;
        if ({halt, fault, halt_code, fault_addr} !== 66'h0) begin
            errors++;
            $display("FAIL rst_flags got %b %b %h %h want 0",
                     halt, fault, halt_code, fault_addr);
        end
    endtask

    task automatic test_cycle_count();
        logic [31:0] v;
        @(negedge clk);
        do_reset();
        repeat (10) @(negedge clk);
        do_read(32'h1000_0000, v);
        checks++;
        if (v !== 32'd10) begin
            errors++;
            $display("FAIL cycle_10 got %h want %h", v, 32'd10);
        end
        do_read(32'h1000_0004, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL cycle_hi_0 got %h want %h", v, 32'd0);
        end
        @(negedge clk);
        force dut.cycle_cnt_q = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cycle_cnt_q;
        @(negedge clk);
        do_read(32'h1000_0004, v);
        checks++;
        if (v !== 32'd1) begin
            errors++;
            $display("FAIL carry_hi got %h want %h", v, 32'd1);
        end
        do_read(32'h1000_0000, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL carry_lo got %h want %h", v, 32'd0);
        end
    endtask

    task automatic test_word_store();
        logic [31:0] v;
        @(negedge clk);
        do_reset();
        do_store(3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        do_read(32'h0000_0100, v);
        checks++;
        if (v !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL sw_read got %h want %h", v, 32'hDEAD_BEEF);
        end
        do_read(32'h1000_000C, v);
        checks++;
        if (v !== 32'd1) begin
            errors++;
            $display("FAIL sw_store_cnt got %h want %h", v, 32'd1);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] v;
        @(negedge clk);
        do_store(3'b000, 32'h0000_0101, 32'h1234_56AA);
        do_read(32'h0000_0100, v);
        checks++;
        if (v !== 32'hDEAD_AAEF) begin
            errors++;
            $display("FAIL sb_lane1 got %h want %h", v, 32'hDEAD_AAEF);
        end
        @(negedge clk);
        do_store(3'b001, 32'h0000_0102, 32'hFFFF_1234);
        do_read(32'h0000_0100, v);
        checks++;
        if (v !== 32'h1234_AAEF) begin
            errors++;
            $display("FAIL sh_upper got %h want %h", v, 32'h1234_AAEF);
        end
        do_read(32'h1000_000C, v);
        checks++;
        if (v !== 32'd3) begin
            errors++;
            $display("FAIL bh_store_cnt got %h want %h", v, 32'd3);
        end
    endtask

    task automatic test_fault();
        logic [31:0] v;
        @(negedge clk);
        do_store(3'b001, 32'h0000_0103, 32'h0000_FFFF);
        do_store(3'b010, 32'h0000_0102, 32'h5555_5555);
        do_store(3'b100, 32'h0000_0100, 32'h6666_6666);
        do_store(3'b000, 32'h1000_0008, 32'h0000_0007);
        do_read(32'h0000_0100, v);
        checks++;
        if (v !== 32'h1234_AAEF) begin
            errors++;
            $display("FAIL fault_nowrite got %h want %h", v, 32'h1234_AAEF);
        end
        checks++;
        if (fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_flag got %b want 1", fault);
        end
        checks++;
        if (fault_addr !== 32'h0000_0103) begin
            errors++;
            $display("FAIL fault_addr got %h want %h", fault_addr, 32'h103);
        end
        checks++;
        if ({halt, halt_code} !== 33'h0) begin
            errors++;
            $display("FAIL fault_mmio_sb got %b %h want 0", halt, halt_code);
        end
        do_read(32'h1000_000C, v);
        checks++;
        if (v !== 32'd3) begin
            errors++;
            $display("FAIL fault_store_cnt got %h want %h", v, 32'd3);
        end
    endtask

    task automatic test_same_cycle_read();
        logic [31:0] v;
        @(negedge clk);
        do_store(3'b010, 32'h0000_0200, 32'h1111_1111);
        bus.ram_write = 1'b1;
        bus.write_type = 3'b010;
        bus.mem_addr = 32'h0000_0200;
        bus.mem_write_data = 32'h2222_2222;
        #1;
        v = bus.mem_read_data;
        checks++;
        if (v !== 32'h1111_1111) begin
            errors++;
            $display("FAIL rdw_old got %h want %h", v, 32'h1111_1111);
        end
        @(negedge clk);
        do_read(32'h0000_0200, v);
        checks++;
        if (v !== 32'h2222_2222) begin
            errors++;
            $display("FAIL rdw_new got %h want %h", v, 32'h2222_2222);
        end
    endtask

    task automatic test_alias_ro();
        logic [31:0] v;
        @(negedge clk);
        do_reset();
        do_store(3'b010, 32'h0000_4100, 32'hCAFE_F00D);
        do_read(32'h0000_0100, v);
        checks++;
        if (v !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL alias got %h want %h", v, 32'hCAFE_F00D);
        end
        @(negedge clk);
        do_store(3'b010, 32'h1000_000C, 32'h0000_0055);
        do_read(32'h1000_000C, v);
        checks++;
        if (v !== 32'd1) begin
            errors++;
            $display("FAIL ro_store_cnt got %h want %h", v, 32'd1);
        end
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL ro_nofault got %b want 0", fault);
        end
    endtask

    task automatic test_halt();
        logic [31:0] v;
        @(negedge clk);
        do_reset();
        do_store(3'b010, 32'h1000_0008, 32'h0000_0000);
        checks++;
        if (halt !== 1'b0) begin
            errors++;
            $display("FAIL tohost_zero got %b want 0", halt);
        end
        do_store(3'b010, 32'h1000_0008, 32'h0000_0001);
        checks++;
        if ({halt, halt_code} !== {1'b1, 32'h1}) begin
            errors++;
            $display("FAIL halt_set got %b %h want 1 1", halt, halt_code);
        end
        do_store(3'b010, 32'h0000_0100, 32'h9999_9999);
        do_store(3'b010, 32'h1000_0008, 32'h0000_0005);
        do_store(3'b001, 32'h0000_0101, 32'h0000_0000);
        repeat (3) @(negedge clk);
        do_read(32'h0000_0100, v);
        checks++;
        if (v !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL halt_ignore got %h want %h", v, 32'hCAFE_F00D);
        end
        checks++;
        if ({halt_code, fault} !== {32'h1, 1'b0}) begin
            errors++;
            $display("FAIL halt_frozen_regs got %h %b want 1 0",
                     halt_code, fault);
        end
        do_read(32'h1000_0000, v);
        checks++;
        if (v !== 32'd2) begin
            errors++;
            $display("FAIL halt_cycle got %h want %h", v, 32'd2);
        end
    endtask

    task automatic test_reset_priority();
        logic [31:0] v;
        @(negedge clk);
        rst = 1'b1;
        bus.ram_write = 1'b1;
        bus.write_type = 3'b010;
        bus.mem_addr = 32'h0000_0100;
        bus.mem_write_data = 32'h7777_7777;
        @(negedge clk);
        bus.ram_write = 1'b0;
        rst = 1'b0;
        do_read(32'h0000_0100, v);
        checks++;
        if (v !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rstprio_ram got %h want %h", v, 32'hCAFE_F00D);
        end
        do_read(32'h1000_000C, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL rstprio_cnt got %h want %h", v, 32'd0);
        end
        checks++;
        if (halt !== 1'b0) begin
            errors++;
            $display("FAIL rstprio_halt got %b want 0", halt);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.ram_write = 1'b0;
        bus.write_type = 3'b010;
        bus.mem_addr = 32'h0;
        bus.mem_write_data = 32'h0;
        test_reset();
        test_cycle_count();
        test_word_store();
        test_byte_half();
        test_fault();
        test_same_cycle_read();
        test_alias_ro();
        test_halt();
        test_reset_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
